// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I pipeline control slice: FSM states, x0 constant
// and the per-cycle enable/flush bundle driven onto the pipeline registers.
package rv32i_pkg;

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_bubble;
  } ctrl_t;

  // Bit order follows the struct: pc, if_id en/flush, id_ex en/flush, ex_mem, bubble
  localparam ctrl_t CTRL_RUN    = 7'b1101010;
  localparam ctrl_t CTRL_RESET  = 7'b0010101;
  localparam ctrl_t CTRL_FREEZE = 7'b0000001;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose rd feeds an operand read in ID.
module hazard_detect
  import rv32i_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic hit_rs1, hit_rs2;

  assign hit_rs1  = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit_rs2  = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rd != REG_X0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory wait FSM with
// timeout, branch squash, load-use stall, and a saturating stall counter.
module pipeline_ctrl
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int              WC_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            load_use;
  logic            mem_hold;
  ctrl_t           run_ctrl;
  ctrl_t           ctrl;

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_MemRead),
    .load_use    (load_use)
  );

  // A released wait (MEM_WAIT with ready) falls through to normal RUN decoding
  assign mem_hold = (state == MEM_ERR)
                 || (state == MEM_WAIT && !dmem_ready)
                 || (state == RUN && dmem_req && !dmem_ready);

  always_comb begin
    run_ctrl = CTRL_RUN;
    if (ex_branch_taken) begin
      run_ctrl.if_id_flush = 1'b1;
      run_ctrl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      run_ctrl.pc_en       = 1'b0;
      run_ctrl.if_id_en    = 1'b0;
      run_ctrl.id_ex_flush = 1'b1;
    end
    ctrl = rst ? CTRL_RESET : (mem_hold ? CTRL_FREEZE : run_ctrl);
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_en      = ctrl.id_ex_en;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_count <= '0;
      mem_err     <= 1'b0;
    end else begin
      if (!ctrl.pc_en && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
      case (state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= WAIT_LAST) begin
            state   <= MEM_ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        MEM_ERR: mem_err <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench: each driven cycle queues its expected controls,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipeline_ctrl;

  localparam int TO  = 4;
  localparam int CW  = 4;

  // ctrl order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble
  localparam logic [6:0] E_RST = 7'b0010101;
  localparam logic [6:0] E_RUN = 7'b1101010;
  localparam logic [6:0] E_FRZ = 7'b0000001;
  localparam logic [6:0] E_BR  = 7'b1111110;
  localparam logic [6:0] E_LU  = 7'b0001110;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_MemRead = 1'b0;
  logic          ex_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
  logic          mem_wb_bubble, mem_err;
  logic [CW-1:0] stall_count;

  typedef struct {
    logic [6:0]    ctrl;
    logic          err;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err), .stall_count(stall_count)
  );

  // Monitor: outputs are combinational, so every cycle presents a response
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      e   = exp_q.pop_front();
      got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble};
      n_checks += 3;
      if (got !== e.ctrl) begin
        n_fail++;
        $display("FAIL %s ctrl: got %b expected %b", e.name, got, e.ctrl);
      end
      if (mem_err !== e.err) begin
        n_fail++;
        $display("FAIL %s mem_err: got %b expected %b", e.name, mem_err, e.err);
      end
      if (stall_count !== e.cnt) begin
        n_fail++;
        $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.cnt);
      end
    end
  end

  // One cycle of stimulus; expectations describe what is visible this cycle
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mrd, input logic br, input logic req, input logic rdy,
                      input logic [6:0] ectrl, input logic eerr, input int ecnt,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_MemRead = mrd; ex_branch_taken = br; dmem_req = req; dmem_ready = rdy;
    e.ctrl = ectrl; e.err = eerr; e.cnt = CW'(ecnt); e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [6:0] ectrl, input logic eerr, input int ecnt, input string nm);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ectrl, eerr, ecnt, nm);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, 0, 0, "reset0");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_RST, 0, 0, "reset_busy_inputs");
    idle(E_RUN, 0, 0, "run_idle");
    step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, E_LU,  0, 0, "loaduse_rs1");
    idle(E_RUN, 0, 1, "after_lu1");
    step(0, 3, 9, 0, 1, 9, 1, 0, 0, 0, E_LU,  0, 1, "loaduse_rs2");
    step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, E_RUN, 0, 2, "x0_no_stall");
    step(0, 3, 7, 1, 0, 7, 1, 0, 0, 0, E_RUN, 0, 2, "rs2_unused");
    step(0, 5, 0, 1, 0, 5, 0, 0, 0, 0, E_RUN, 0, 2, "not_a_load");
    step(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, E_BR,  0, 2, "branch_over_lu");
    idle(E_RUN, 0, 2, "after_branch");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 0, 2, "ready_no_req");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN, 0, 2, "req_ready_same");
    // 3-cycle wait with a branch held; it only takes effect on release
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ, 0, 2, "wait_run");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ, 0, 3, "wait_1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ, 0, 4, "wait_2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, E_BR,  0, 5, "wait_release_br");
    idle(E_RUN, 0, 5, "back_to_run");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 5, "wait_b");
    step(0, 6, 0, 1, 0, 6, 1, 0, 1, 1, E_LU,  0, 6, "release_lu");
    idle(E_RUN, 0, 7, "after_release_lu");
    // reset during the second MEM_WAIT cycle
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 7, "rw_run");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 8, "rw_wait1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_RST, 0, 9, "rw_reset");
    idle(E_RUN, 0, 0, "rw_after");
    // timeout: four frozen cycles, then sticky error
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 0, "to_run");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 1, "to_w1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 2, "to_w2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 3, "to_w3");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, E_FRZ, 1, 4, "err_ready");
    for (int i = 0; i < 13; i++)
      idle(E_FRZ, 1, (5 + i > 15) ? 15 : 5 + i, "err_hold_sat");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, 1, 15, "err_reset");
    idle(E_RUN, 0, 0, "err_cleared");
    idle(E_RUN, 0, 0, "final_idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
